// File: rtl/cdc_handshake_receiver.sv
// Destination-side receiver for a toggle req/ack multi-bit CDC transfer.
// Define CDC_HS_RX_FIFO_EN for a 2-entry output FIFO that acks on capture.

module cdc_synchronizer #(
  parameter int DATA_WIDTH   = 1,
  parameter int SYNC_TIMES   = 3,
  parameter int SMOOTH_TIMES = 1
) (
  input  logic                  clk,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);
  localparam int DEPTH = SYNC_TIMES + SMOOTH_TIMES;

  // No reset on purpose: the receiver's INIT state waits for this chain to flush.
  logic [DATA_WIDTH-1:0] chain [DEPTH];

  always_ff @(posedge clk) begin
    chain[0] <= din;
    for (int i = 1; i < DEPTH; i++) chain[i] <= chain[i-1];
  end

  assign dout = chain[DEPTH-1];
endmodule

module cdc_handshake_receiver #(
  parameter int DATA_WIDTH    = 8,
  parameter int SYNC_TIMES    = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_toggle,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ack_toggle,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  proto_err,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_IDLE   = 2'd1,
    S_SETTLE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  localparam int CNT_MAX = (SYNC_TIMES + 1 > 15) ? SYNC_TIMES + 1 : 15;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(SYNC_TIMES + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             req_sync_raw, req_sync, last_req, req_change;
  logic             capture, load_last, accept, can_start, err_set;

  cdc_synchronizer #(
    .DATA_WIDTH  (1),
    .SYNC_TIMES  (SYNC_TIMES),
    .SMOOTH_TIMES(1)
  ) u_req_sync (
    .clk (clk),
    .din (req_toggle),
    .dout(req_sync_raw)
  );

  // Edge-detect register; flushed by INIT after reset, so it carries no reset.
  always_ff @(posedge clk) req_sync <= req_sync_raw;

  assign req_change = (req_sync != last_req);
  // out_valid/out_ready: a word moves at a posedge where both are high;
  // out_data is stable for as long as out_valid is high.
  assign accept     = out_valid & out_ready;

`ifdef CDC_HS_RX_FIFO_EN
  localparam state_t CAP_STATE = S_IDLE;

  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  wr_ptr, rd_ptr;
  logic [1:0]            fifo_cnt;

  assign can_start = (fifo_cnt != 2'd2);
  // A second toggle before the capture edge (which is the ack) cancels the first.
  assign err_set   = (state == S_SETTLE) && !req_change;
  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_cnt    <= 2'd0;
      ack_toggle  <= 1'b0;
    end else begin
      if (capture) begin
        fifo_mem[wr_ptr] <= data_in;
        wr_ptr           <= ~wr_ptr;
        ack_toggle       <= ~ack_toggle;
      end
      if (accept) rd_ptr <= ~rd_ptr;
      case ({capture, accept})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  localparam state_t CAP_STATE = S_HOLD;

  assign can_start = 1'b1;
  assign err_set   = (state == S_HOLD) && req_change;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      ack_toggle <= 1'b0;
    end else if (capture) begin
      out_data  <= data_in;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid  <= 1'b0;
      ack_toggle <= ~ack_toggle;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    load_last = 1'b0;
    case (state)
      S_INIT: begin
        if (cnt == INIT_LAST) begin
          load_last = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (req_change && can_start) begin
          if (SETTLE_CYCLES == 0) begin
            capture   = 1'b1;
            state_nxt = CAP_STATE;
          end else begin
            cnt_nxt   = '0;
            state_nxt = S_SETTLE;
          end
        end
      end
      S_SETTLE: begin
        if (cnt == SETTLE_LAST) begin
          capture   = 1'b1;
          cnt_nxt   = '0;
          state_nxt = CAP_STATE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (accept) state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      cnt       <= '0;
      last_req  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (load_last || capture) last_req <= req_sync;
      if (err_set) proto_err <= 1'b1;
    end
  end

  assign busy      = (state != S_IDLE) || out_valid;
  assign dbg_state = state;
endmodule
